// File: rtl/aes_inv_key_schedule.sv
// Byte-serial AES-128 inverse key schedule: loaded with the round-10 key, each step rolls it back one round in place.
// Optional INV_KS_SBOX_REG_EN registers the S-box output and inserts a one-cycle PAD state before word 0.
module aes_inv_key_schedule (
    input  logic       clk,
    input  logic       rstn,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [7:0] key_byte,
    input  logic       step_req,
    output logic       busy,
    output logic       ko_valid,
    output logic [7:0] ko_byte,
    output logic [3:0] ko_idx,
    output logic       step_done,
    output logic [3:0] rnd,
    output logic [1:0] dbg_state
);

    // Handshake: a key byte transfers on any rising edge where key_valid && key_ready;
    // ko_* has no backpressure and is valid only while ko_valid is high.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
`ifdef INV_KS_SBOX_REG_EN
    localparam logic [1:0] S_PAD  = 2'd3;
`endif

    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [1:0] r_state;
    logic [7:0] r_key [16];
    logic [3:0] r_lcnt;
    logic [3:0] r_cnt;
    logic [3:0] r_rnd;
    logic [7:0] r_rcon;
    logic       r_ko_valid;
    logic [7:0] r_ko_byte;
    logic [3:0] r_ko_idx;
    logic       r_step_done;

    logic [3:0] w_idx;
    logic [7:0] w_sbox_in;
    logic [7:0] w_sbox_out;
    logic [7:0] w_sbox_q;
    logic [7:0] w_new;
    logic [7:0] w_rcon_next;
    logic       w_key_fire;

    // Byte counter 0..15 maps to word order 3,2,1,0 with bytes ascending inside each word.
    assign w_idx      = {~r_cnt[3:2], r_cnt[1:0]};
    assign w_sbox_out = SBOX_TAB[{~w_sbox_in, 3'b000} +: 8];
    assign w_key_fire = key_valid && key_ready;

`ifdef INV_KS_SBOX_REG_EN
    logic [7:0] r_sbox;

    // Prefetch the operand for the next word-0 byte; PAD primes byte 0 (operand k[13]).
    assign w_sbox_in = (r_state == S_PAD) ? r_key[13] : r_key[{2'b11, r_cnt[1:0] + 2'd2}];
    assign w_sbox_q  = r_sbox;

    always_ff @(posedge clk) begin
        r_sbox <= w_sbox_out;
    end
`else
    assign w_sbox_in = r_key[{2'b11, r_cnt[1:0] + 2'd1}];
    assign w_sbox_q  = w_sbox_out;
`endif

    always_comb begin
        w_new = r_key[w_idx] ^ r_key[w_idx - 4'd4];
        if (w_idx[3:2] == 2'b00) begin
            w_new = r_key[w_idx] ^ w_sbox_q ^ ((w_idx[1:0] == 2'b00) ? r_rcon : 8'h00);
        end
    end

    assign w_rcon_next = r_rcon[0] ? (((r_rcon ^ 8'h1b) >> 1) | 8'h80) : (r_rcon >> 1);

    // Key storage carries no reset: its contents are meaningless until rnd is non-zero.
    always_ff @(posedge clk) begin
        if (w_key_fire) begin
            r_key[r_lcnt] <= key_byte;
        end else if (r_state == S_STEP) begin
            r_key[w_idx] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_lcnt      <= 4'd0;
            r_cnt       <= 4'd0;
            r_rnd       <= 4'd0;
            r_rcon      <= 8'h00;
            r_ko_valid  <= 1'b0;
            r_ko_byte   <= 8'h00;
            r_ko_idx    <= 4'd0;
            r_step_done <= 1'b0;
        end else begin
            r_ko_valid  <= 1'b0;
            r_step_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (key_valid) begin
                        r_lcnt  <= r_lcnt + 4'd1;
                        r_state <= S_LOAD;
                    end else if (step_req && (r_rnd != 4'd0)) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_STEP;
                    end
                end
                S_LOAD: begin
                    if (key_valid) begin
                        r_lcnt <= r_lcnt + 4'd1;
                        if (r_lcnt == 4'd15) begin
                            r_state <= S_IDLE;
                            r_rnd   <= 4'd10;
                            r_rcon  <= 8'h36;
                        end
                    end
                end
                S_STEP: begin
                    r_ko_valid <= 1'b1;
                    r_ko_byte  <= w_new;
                    r_ko_idx   <= w_idx;
                    r_cnt      <= r_cnt + 4'd1;
`ifdef INV_KS_SBOX_REG_EN
                    if (r_cnt == 4'd11) begin
                        r_state <= S_PAD;
                    end
`endif
                    if (r_cnt == 4'd15) begin
                        r_state     <= S_IDLE;
                        r_step_done <= 1'b1;
                        r_rnd       <= r_rnd - 4'd1;
                        r_rcon      <= w_rcon_next;
                    end
                end
`ifdef INV_KS_SBOX_REG_EN
                S_PAD: begin
                    r_state <= S_STEP;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign key_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
`ifdef INV_KS_SBOX_REG_EN
    assign busy      = (r_state == S_STEP) || (r_state == S_PAD);
`else
    assign busy      = (r_state == S_STEP);
`endif
    assign ko_valid  = r_ko_valid;
    assign ko_byte   = r_ko_byte;
    assign ko_idx    = r_ko_idx;
    assign step_done = r_step_done;
    assign rnd       = r_rnd;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule: FIPS-197 A.1 round keys checked through the ko_* byte stream.
module tb_aes_inv_key_schedule;

    logic       clk;
    logic       rstn;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_byte;
    logic       step_req;
    logic       busy;
    logic       ko_valid;
    logic [7:0] ko_byte;
    logic [3:0] ko_idx;
    logic       step_done;
    logic [3:0] rnd;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

`ifdef INV_KS_SBOX_REG_EN
    localparam int STEP_CYC = 17;
`else
    localparam int STEP_CYC = 16;
`endif

    localparam logic [127:0] RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    // Expected stream entries: {ko_idx, ko_byte}.
    logic [11:0] exp_q[$];

    aes_inv_key_schedule dut (
        .clk       (clk),
        .rstn      (rstn),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_byte  (key_byte),
        .step_req  (step_req),
        .busy      (busy),
        .ko_valid  (ko_valid),
        .ko_byte   (ko_byte),
        .ko_idx    (ko_idx),
        .step_done (step_done),
        .rnd       (rnd),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_key(input logic [127:0] key);
        int order [16] = '{12, 13, 14, 15, 8, 9, 10, 11, 4, 5, 6, 7, 0, 1, 2, 3};
        for (int c = 0; c < 16; c++) begin
            exp_q.push_back({order[c][3:0], key[127 - 8 * order[c] -: 8]});
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        for (int i = 0; i < 16; i++) begin
            key_valid = 1'b1;
            key_byte  = key[127 - 8 * i -: 8];
            @(posedge clk);
            #1;
        end
        key_valid = 1'b0;
    endtask

    task automatic wait_step_done(input int start_n, output int n);
        n = start_n;
        while (!step_done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("step_done_seen", step_done, 1'b1);
    endtask

    task automatic do_step();
        int n;
        step_req = 1'b1;
        @(posedge clk);
        #1;
        step_req = 1'b0;
        chk("busy_after_req", busy, 1'b1);
        wait_step_done(0, n);
        chk("step_cycles", n, STEP_CYC);
        @(posedge clk);
        #1;
        chk("busy_after_step", busy, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ko_valid"}, ko_valid, 1'b0);
        chk({tag, "_ko_byte"}, ko_byte, 8'h00);
        chk({tag, "_ko_idx"}, ko_idx, 4'd0);
        chk({tag, "_step_done"}, step_done, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_rnd"}, rnd, 4'd0);
        chk({tag, "_key_ready"}, key_ready, 1'b1);
    endtask

    // Scoreboard: every ko_valid beat must match the head of exp_q; step_done only with idx 3.
    always @(negedge clk) begin
        if (ko_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ko", {ko_idx, ko_byte}, 12'h000);
                chk("unexpected_ko_valid", ko_valid, 1'b0);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                chk("ko_stream", {step_done, ko_idx, ko_byte}, {(e[11:8] == 4'd3), e});
            end
        end
    end

    initial begin
        int n;
        rstn      = 1'b0;
        key_valid = 1'b0;
        key_byte  = 8'h00;
        step_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        chk("por_state", dbg_state, 2'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // step_req with rnd == 0 is ignored
        step_req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        step_req = 1'b0;
        chk("rnd0_busy", busy, 1'b0);
        chk("rnd0_rnd", rnd, 4'd0);
        chk("rnd0_state", dbg_state, 2'd0);

        // load round-10 key, one step to round 9
        load_key(RK[10]);
        chk("load_rnd", rnd, 4'd10);
        chk("load_state", dbg_state, 2'd0);
        push_key(RK[9]);
        do_step();
        chk("step1_rnd", rnd, 4'd9);

        // reload with step_req raised while in LOAD: no step may start
        for (int i = 0; i < 16; i++) begin
            key_valid = 1'b1;
            key_byte  = RK[10][127 - 8 * i -: 8];
            step_req  = (i >= 1 && i < 15);
            @(posedge clk);
            #1;
            if (i == 5) chk("load_req_state", dbg_state, 2'd1);
        end
        key_valid = 1'b0;
        step_req  = 1'b0;
        chk("reload_rnd", rnd, 4'd10);
        chk("reload_busy", busy, 1'b0);

        // key_valid held during a step must stall and not disturb the key
        push_key(RK[9]);
        step_req = 1'b1;
        @(posedge clk);
        #1;
        step_req  = 1'b0;
        key_valid = 1'b1;
        key_byte  = 8'hff;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("step_key_ready", key_ready, 1'b0);
        end
        key_valid = 1'b0;
        wait_step_done(5, n);
        @(posedge clk);
        #1;
        chk("stall_rnd", rnd, 4'd9);
        chk("stall_state", dbg_state, 2'd0);
        push_key(RK[8]);
        do_step();
        chk("step_r8_rnd", rnd, 4'd8);

        // asynchronous reset at c=7 of a step
        load_key(RK[10]);
        push_key(RK[9]);
        step_req = 1'b1;
        @(posedge clk);
        #1;
        step_req = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        load_key(RK[10]);
        push_key(RK[9]);
        do_step();
        chk("post_rst_rnd", rnd, 4'd9);

        // step_req held high: ten back-to-back steps down to round 0
        load_key(RK[10]);
        for (int r = 9; r >= 0; r--) push_key(RK[r]);
        step_req = 1'b1;
        n = 0;
        while (rnd != 4'd0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        step_req = 1'b0;
        chk("held_rnd", rnd, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("held_busy", busy, 1'b0);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
